// File: rtl/known_sinks_writer.sv
// rtl/known_sinks_writer.sv - builds the knownSinks table in byte-wide node memory
// Dedups 16-bit sink IDs against occupied slots, appends new ones big-endian, and wipes the table on clear.
module known_sinks_writer #(
  parameter int                    WORD_WIDTH  = 16,
  parameter int                    MEM_WIDTH   = 8,
  parameter logic [15:0]           BASE_ADDR   = 16'h0008,
  parameter int                    NUM_ENTRIES = 16,
  parameter logic [WORD_WIDTH-1:0] EMPTY_ID    = 16'hFFFF,
  localparam int                   CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] sink_id,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic                  clear,
  output logic [15:0]           mem_rd_addr,
  input  logic [WORD_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [15:0]           mem_wr_addr,
  output logic [MEM_WIDTH-1:0]  mem_wr_data,
  output logic [CNT_W-1:0]      sink_count,
  output logic                  table_full,
  output logic                  done,
  output logic [1:0]            status
);

  localparam int CLR_W    = $clog2(2 * NUM_ENTRIES);
  localparam int CLR_LAST = 2 * NUM_ENTRIES - 1;

  localparam logic [1:0] ST_ADDED   = 2'b00;
  localparam logic [1:0] ST_DUP     = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;
  localparam logic [1:0] ST_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    WR_HI,
    WR_LO,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] id_q, id_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      scan_idx_q, scan_idx_d;
  logic [CLR_W-1:0]      clr_idx_q, clr_idx_d;
  logic [15:0]           rd_addr_q, rd_addr_d;
  logic [1:0]            status_q, status_d;
  logic [15:0]           slot_addr;
  logic                  full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      id_q       <= '0;
      count_q    <= '0;
      scan_idx_q <= '0;
      clr_idx_q  <= '0;
      rd_addr_q  <= BASE_ADDR;
      status_q   <= ST_ADDED;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      count_q    <= count_d;
      scan_idx_q <= scan_idx_d;
      clr_idx_q  <= clr_idx_d;
      rd_addr_q  <= rd_addr_d;
      status_q   <= status_d;
    end
  end

  assign full      = (count_q == CNT_W'(NUM_ENTRIES));
  // Next free slot: new IDs are always appended after the occupied region.
  assign slot_addr = BASE_ADDR + 16'({count_q, 1'b0});

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    count_d    = count_q;
    scan_idx_d = scan_idx_q;
    clr_idx_d  = clr_idx_q;
    rd_addr_d  = rd_addr_q;
    status_d   = status_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else if (sink_valid) begin
          id_d = sink_id;
          if (sink_id == EMPTY_ID) begin
            state_d  = DONE;
            status_d = ST_INVALID;
          end else if (count_q == '0) begin
            state_d = WR_HI;
          end else begin
            state_d    = SCAN;
            rd_addr_d  = BASE_ADDR;
            scan_idx_d = '0;
          end
        end
      end
      CLEAR: begin
        if (clr_idx_q == CLR_W'(CLR_LAST)) begin
          count_d  = '0;
          status_d = ST_INVALID;
          state_d  = DONE;
        end else begin
          clr_idx_d = clr_idx_q + CLR_W'(1);
        end
      end
      SCAN: begin
        if (mem_rd_data == id_q) begin
          state_d  = DONE;
          status_d = ST_DUP;
        end else if (scan_idx_q + CNT_W'(1) == count_q) begin
          // Full is only reported once no occupied slot matched.
          if (full) begin
            state_d  = DONE;
            status_d = ST_FULL;
          end else begin
            state_d = WR_HI;
          end
        end else begin
          rd_addr_d  = rd_addr_q + 16'd2;
          scan_idx_d = scan_idx_q + CNT_W'(1);
        end
      end
      WR_HI: state_d = WR_LO;
      WR_LO: begin
        count_d  = count_q + CNT_W'(1);
        status_d = ST_ADDED;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = BASE_ADDR;
    mem_wr_data = '0;
    case (state_q)
      CLEAR: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = BASE_ADDR + 16'(clr_idx_q);
        mem_wr_data = '1;
      end
      WR_HI: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = slot_addr;
        mem_wr_data = id_q[WORD_WIDTH-1:MEM_WIDTH];
      end
      WR_LO: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = slot_addr + 16'd1;
        mem_wr_data = id_q[MEM_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  assign sink_ready  = (state_q == IDLE) && !clear;
  assign done        = (state_q == DONE);
  assign status      = status_q;
  assign sink_count  = count_q;
  assign table_full  = full;
  assign mem_rd_addr = rd_addr_q;

endmodule
